// File: rtl/ras_ctrl.sv
// Fetch-stage return-address-stack controller: decodes RISC-V call/return hints,
// strobes the external LIFO, registers the return prediction and mirrors LIFO occupancy.
module ras_ctrl #(
  parameter  int DATA_WIDTH = 32,
  parameter  int RAS_DEPTH  = 4,
  localparam int OCC_W      = $clog2(RAS_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_valid_i,
  input  logic [31:0]           inst_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  lifo_empty_i,
  input  logic                  lifo_full_i,
  input  logic [DATA_WIDTH-1:0] lifo_data_i,
  output logic                  push_o,
  output logic                  pop_o,
  output logic                  read_lifo_o,
  output logic [DATA_WIDTH-1:0] push_data_o,
  output logic                  pred_valid_o,
  output logic [DATA_WIDTH-1:0] pred_target_o,
  output logic [DATA_WIDTH-1:0] pred_pc_o,
  output logic [OCC_W-1:0]      occupancy_o,
  output logic [15:0]           underflow_cnt_o,
  output logic                  sync_err_o
);

  typedef enum logic {IDLE, PRED} state_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [6:0] opcode;
  logic [4:0] rd, rs1;
  logic       is_jal, is_jalr, rd_link, rs1_link, rs_ne_rd;
  logic       call_push, ret_pop, pop_then_push;
  logic       fire_p0, underflow_p0;
  logic       unused_inst;

  state_t                  state_p1, state_nx;
  logic [DATA_WIDTH-1:0]   pred_target_p1, pred_pc_p1;
  logic [OCC_W-1:0]        occ_p1, occ_nx;
  logic [15:0]             uf_cnt_p1;
  logic                    sync_err_p1, mismatch_p0;

  // Stage p0: decode and combinational LIFO strobes
  assign opcode   = inst_i[6:0];
  assign rd       = inst_i[11:7];
  assign rs1      = inst_i[19:15];
  assign is_jal   = (opcode == 7'b1101111);
  assign is_jalr  = (opcode == 7'b1100111);
  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);
  assign rs_ne_rd = (rs1 != rd);

  assign unused_inst = ^{inst_i[31:20], inst_i[14:12]};

  assign call_push     = (is_jal & rd_link) | (is_jalr & rd_link & ~(rs1_link & rs_ne_rd));
  assign ret_pop       = is_jalr & ~rd_link & rs1_link;
  assign pop_then_push = is_jalr & rd_link & rs1_link & rs_ne_rd;

  assign fire_p0      = inst_valid_i & ~stall_i & ~flush_i & reset;
  assign push_o       = fire_p0 & (call_push | pop_then_push);
  assign pop_o        = fire_p0 & (ret_pop | pop_then_push) & ~lifo_empty_i;
  assign read_lifo_o  = pop_o;
  assign underflow_p0 = fire_p0 & (ret_pop | pop_then_push) & lifo_empty_i;
  assign push_data_o  = pc_i + DATA_WIDTH'(4);

  assign mismatch_p0 = ((occ_p1 == '0) != lifo_empty_i) |
                       ((occ_p1 == OCC_W'(RAS_DEPTH)) != lifo_full_i);

  always_comb begin
    state_nx = state_p1;
    if (flush_i)
      state_nx = IDLE;
    else if (fire_p0)
      state_nx = pop_o ? PRED : IDLE;
  end

  // Mirror wraps to one entry on a push while full, as the LIFO does
  always_comb begin
    occ_nx = occ_p1;
    case ({push_o, pop_o})
      2'b10:   occ_nx = (occ_p1 == OCC_W'(RAS_DEPTH)) ? OCC_W'(1) : occ_p1 + OCC_W'(1);
      2'b01:   occ_nx = occ_p1 - OCC_W'(1);
      default: occ_nx = occ_p1;
    endcase
  end

  // Stage p1: registered prediction and debug state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1       <= IDLE;
      pred_target_p1 <= '0;
      pred_pc_p1     <= '0;
      occ_p1         <= '0;
      uf_cnt_p1      <= '0;
      sync_err_p1    <= 1'b0;
    end else begin
      state_p1 <= state_nx;
      if (fire_p0 && pop_o) begin
        pred_target_p1 <= lifo_data_i;
        pred_pc_p1     <= pc_i;
      end
      occ_p1 <= occ_nx;
      if (underflow_p0)
        uf_cnt_p1 <= sat_inc(uf_cnt_p1);
      sync_err_p1 <= sync_err_p1 | mismatch_p0;
    end
  end

  assign pred_valid_o    = (state_p1 == PRED);
  assign pred_target_o   = pred_target_p1;
  assign pred_pc_o       = pred_pc_p1;
  assign occupancy_o     = occ_p1;
  assign underflow_cnt_o = uf_cnt_p1;
  assign sync_err_o      = sync_err_p1;

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
Return-address-stack controller sitting directly upstream of the core's LIFO return-address stack, in the fetch stage.
- Decodes each fetched instruction for RISC-V call/return hints and drives the LIFO push/pop/read strobes.
- Supplies PC+4 as push data and registers the popped address as a predicted return target for fetch.
- Mirrors the LIFO occupancy and counts underflows for debug.

Parameters:
DATA_WIDTH, 32, address width; equals the LIFO data width.
RAS_DEPTH, 4, LIFO depth; must equal the LIFO's depth parameter.

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
inst_valid_i  input  1  fetched instruction valid
inst_i  input  32  fetched instruction word
pc_i  input  DATA_WIDTH  PC of inst_i
stall_i  input  1  fetch stall; instruction not consumed this cycle
flush_i  input  1  pipeline flush; kills the current instruction
lifo_empty_i  input  1  LIFO empty flag
lifo_full_i  input  1  LIFO full flag
lifo_data_i  input  DATA_WIDTH  LIFO top-of-stack data
push_o  output  1  LIFO push strobe
pop_o  output  1  LIFO pop strobe
read_lifo_o  output  1  LIFO read enable
push_data_o  output  DATA_WIDTH  data to push (pc_i + 4)
pred_valid_o  output  1  registered return prediction valid
pred_target_o  output  DATA_WIDTH  registered predicted return address
pred_pc_o  output  DATA_WIDTH  PC of the predicted return
occupancy_o  output  clog2(RAS_DEPTH)+1  mirrored LIFO entry count
underflow_cnt_o  output  16  saturating count of returns seen with an empty stack
sync_err_o  output  1  sticky flag: mirror disagrees with LIFO flags

Behaviour:
- fire = inst_valid_i & ~stall_i & ~flush_i & reset.
- Decode opcode inst[6:0]: 1101111 is JAL, 1100111 is JALR. rd = inst[11:7], rs1 = inst[19:15]. link(r) means r is 1 or 5.
- call_push:
  - JAL with link(rd).
  - JALR with link(rd), except when link(rs1) and rs1 != rd.
- ret_pop: JALR with ~link(rd) and link(rs1).
- pop_then_push: JALR with link(rd), link(rs1) and rs1 != rd. Drives push_o and pop_o together in the same cycle; the LIFO replaces the top entry.
- All LIFO strobes are combinational and qualified by fire:
  - push_o = fire & (call_push | pop_then_push).
  - pop_o = fire & (ret_pop | pop_then_push) & ~lifo_empty_i.
  - read_lifo_o = pop_o.
- push_data_o = pc_i + 4, computed modulo 2^DATA_WIDTH (wraps silently).
- Pop on empty: pop_o is suppressed and underflow_cnt_o increments, saturating at 0xFFFF. pred_valid_o goes to 0 next cycle.
- Prediction registers, one-cycle latency:
  - On fire & pop_o, capture pred_target_o = lifo_data_i (value read before the pointer moves), pred_pc_o = pc_i, and set pred_valid_o = 1.
  - On fire without pop_o, clear pred_valid_o.
  - When stall_i is high, hold all prediction registers.
  - flush_i clears pred_valid_o next cycle regardless of stall_i; flush has priority.
- Occupancy mirror, updated on clk edge:
  - push only: +1 if below RAS_DEPTH; if at RAS_DEPTH it becomes 1, matching the LIFO's wrap-on-full.
  - pop only: -1.
  - push with pop: unchanged.
  - no strobe: unchanged.
- sync_err_o sets (sticky until reset) in any cycle where (occupancy_o == 0) != lifo_empty_i or (occupancy_o == RAS_DEPTH) != lifo_full_i.
- Two-state FSM:
  - IDLE (pred_valid_o = 0) to PRED on a fire that pops.
  - PRED to IDLE on a fire that does not pop, or on flush.
  - PRED to PRED on a new pop.
  - Stall holds the current state.
- Reset (asynchronous assert, synchronous release):
  - Registered outputs: pred_valid_o, pred_target_o, pred_pc_o, occupancy_o, underflow_cnt_o and sync_err_o all go to 0; FSM goes to IDLE.
  - Strobes: push_o, pop_o and read_lifo_o are forced to 0 combinationally while reset is low, including mid-operation.
  - The LIFO must be reset by the same event.
- The LIFO's full/empty flags are combinational from its pointer; there is no combinational loop because push_o and pop_o depend only on decode plus those flags.

Test Plan:
- Reset, then JAL x1 (0x008000EF) at pc 0x100 → push_o = 1, push_data_o = 0x104, occupancy 1; pred_valid_o stays 0.
- After that call, ret (JALR x0,0(x1) = 0x00008067) at pc 0x200 → pop_o = read_lifo_o = 1; next cycle pred_valid_o = 1, pred_target_o = 0x104, pred_pc_o = 0x200, occupancy 0.
- ret with empty stack → pop_o = 0, underflow_cnt_o = 1, pred_valid_o = 0; repeat 0x10000 times → saturates at 0xFFFF.
- Five calls at pcs 0x0, 0x10, 0x20, 0x30, 0x40 with RAS_DEPTH = 4 → occupancy 1,2,3,4,1; sync_err_o stays 0; next ret predicts 0x44.
- JALR x5,0(x1) with occupancy 2 → push_o & pop_o in the same cycle, occupancy stays 2, pred_target_o = old top, new top = pc + 4; then ret with stall_i = 1 for 3 cycles → no strobes, prediction held; then flush_i → pred_valid_o = 0 next cycle.
- Drop reset low mid-stream with pred_valid_o = 1 and occupancy 3 → all registered outputs 0 immediately, strobes low; after release, a call pushes into slot 0.
